donut_shader: RTL

- Pixel-output stage directly downstream of the donut renderer.
- Consumes the renderer's per-pixel hit flag and 6-bit luma, applies a post-reset fade-in gain, and quantises to RGB222 using a 4x4 ordered (Bayer) dither with frame-rotating offsets.
- Composites over a fixed background colour and delays the sync/blanking signals so all outputs reach the VGA pins aligned.

---
 rtl/donut_shader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/donut_shader.sv
// Pixel output stage: fade-in gain, 4x4 ordered dither to RGB222 and compositing
// over a fixed background, with sync delayed to stay aligned with colour.
module donut_shader #(
  parameter int unsigned H_LAST     = 1599,
  parameter int unsigned V_LAST     = 524,
  parameter int unsigned FADE_SHIFT = 2,
  parameter logic [5:0]  BG_RGB     = 6'b000001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] h_count,
  input  logic [9:0]  v_count,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        display_on_in,
  input  logic        donut_visible,
  input  logic [5:0]  donut_luma,
  output logic [1:0]  r,
  output logic [1:0]  g,
  output logic [1:0]  b,
  output logic        hsync,
  output logic        vsync
);

  typedef enum logic {FADE, RUN} state_t;

  state_t                state, state_next;
  logic [7:0]            frame;
  logic [FADE_SHIFT-1:0] fade_cnt, fade_next;
  logic [4:0]            gain, gain_next;
  logic                  tick;

  assign tick = (h_count == 11'(H_LAST)) && (v_count == 10'(V_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FADE;
      frame    <= '0;
      fade_cnt <= '0;
      gain     <= '0;
    end else begin
      state    <= state_next;
      fade_cnt <= fade_next;
      gain     <= gain_next;
      if (tick) frame <= frame + 8'd1;
    end
  end

  always_comb begin
    state_next = state;
    fade_next  = fade_cnt;
    gain_next  = gain;
    case (state)
      FADE: begin
        if (tick) begin
          fade_next = fade_cnt + FADE_SHIFT'(1);
          if (fade_cnt == '1) begin
            gain_next = gain + 5'd1;
            if (gain_next == 5'd16) state_next = RUN;
          end
        end
      end
      RUN: gain_next = 5'd16;
      default: state_next = FADE;
    endcase
  end

  // Stage 1: scaled luma and dither threshold, using frame before any same-edge tick
  logic [10:0] prod;
  logic [1:0]  bx, by;
  logic [3:0]  thr;
  logic [5:0]  ls1;
  logic [3:0]  t1;
  logic        vis1, de1, hs1, vs1;

  assign prod = {5'b0, donut_luma} * {6'b0, gain};
  assign bx   = h_count[1:0] + {1'b0, frame[0]};
  assign by   = v_count[1:0] + {1'b0, frame[1]};

  always_comb begin
    thr = '0;
    case ({by, bx})
      4'h0: thr = 4'd0;   4'h1: thr = 4'd8;   4'h2: thr = 4'd2;   4'h3: thr = 4'd10;
      4'h4: thr = 4'd12;  4'h5: thr = 4'd4;   4'h6: thr = 4'd14;  4'h7: thr = 4'd6;
      4'h8: thr = 4'd3;   4'h9: thr = 4'd11;  4'hA: thr = 4'd1;   4'hB: thr = 4'd9;
      4'hC: thr = 4'd15;  4'hD: thr = 4'd7;   4'hE: thr = 4'd13;  4'hF: thr = 4'd5;
      default: thr = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls1  <= '0;
      t1   <= '0;
      vis1 <= 1'b0;
      de1  <= 1'b0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
    end else begin
      ls1  <= prod[9:4];
      t1   <= thr;
      vis1 <= donut_visible;
      de1  <= display_on_in;
      hs1  <= hsync_in;
      vs1  <= vsync_in;
    end
  end

  // Stage 2: quantise with strict-compare carry, saturate at 3, composite
  logic [2:0] lvl_sum;
  logic [1:0] lvl;

  assign lvl_sum = {1'b0, ls1[5:4]} + {2'b0, (ls1[3:0] > t1)};
  assign lvl     = lvl_sum[2] ? 2'd3 : lvl_sum[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r     <= '0;
      g     <= '0;
      b     <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else begin
      hsync <= hs1;
      vsync <= vs1;
      if (!de1) begin
        r <= '0;
        g <= '0;
        b <= '0;
      end else if (vis1) begin
        r <= lvl;
        g <= lvl;
        b <= {1'b0, lvl[1]};
      end else begin
        r <= BG_RGB[5:4];
        g <= BG_RGB[3:2];
        b <= BG_RGB[1:0];
      end
    end
  end

endmodule
